haar_dwt_frame: RTL and testbench
=================================

# haar_dwt_frame

Parametrised multi-level Haar DWT engine, the frame-based successor to the single-stage average/difference cell in the EEG compression datapath. Accepts a stream of signed EEG samples over a valid/ready handshake, buffers frames of 2^LEVELS samples, and runs LEVELS Haar decomposition levels sequentially (one butterfly per cycle). Emits all 2^LEVELS coefficients in Mallat order over a valid/ready output with level tags, ahead of the quantiser/encoder.

## Interface
- DATA_W, 8: input sample width (signed), legal 4..16
- LEVELS, 3: decomposition levels, legal 1..5; FRAME = 2^LEVELS
- LVL_W, $clog2(LEVELS+1): width of level tag
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset, sampled on rising edge of clk
- s_valid  in  1  input sample valid
- s_ready  out  1  block can accept a sample
- s_data  in  DATA_W  signed input sample
- m_valid  out  1  output coefficient valid
- m_ready  in  1  downstream accepts coefficient
- m_data  out  DATA_W+1  signed coefficient
- m_level  out  LVL_W  0 = final approximation A_L, k = detail D_k
- m_last  out  1  high on the last coefficient of a frame
- busy  out  1  high in COMPUTE or DRAIN

## Operation
- FSM states: FILL, COMPUTE, DRAIN.
- FILL: s_ready=1; each s_valid&&s_ready beat writes the sign-extended sample (DATA_W+1 bits) to buf[wr_cnt]. When the FRAME-th sample is accepted, go to COMPUTE.
- COMPUTE: s_ready=0. Level k=1..LEVELS processes FRAME>>k pairs, one per cycle, pairs in ascending index order. Pair (a,b): avg = (a+b)>>>1, diff = (a-b)>>>1, both computed in DATA_W+2 bits and truncated to DATA_W+1 bits (no overflow possible: averages stay in input range). Averages feed the next level; details D_k are stored. Total 2^LEVELS-1 cycles. Then go to DRAIN.
- DRAIN: present coefficients in order A_L, D_L, D_{L-1}, ..., D_1. Within each level, ascending index. m_level as defined above. m_last on coefficient FRAME-1. Advance only on m_valid&&m_ready. After the last handshake, go to FILL.
- m_data, m_level and m_last are stable while m_valid=1 and m_ready=0.
- >>> is arithmetic, floor rounding: -7>>>1 = -4.
- s_data is ignored when s_valid=0 or s_ready=0. A frame never mixes samples across a reset.

## Timing
- Reset (rst_n low at an edge) gives:
  - state FILL, all counters 0
  - m_valid=0, m_data=0, m_level=0, m_last=0, busy=0
  - s_ready=0 while rst_n is low, 1 in the first cycle after release
- Reset in any state (mid-FILL, mid-COMPUTE, mid-DRAIN) discards the frame. No partial output follows.
- Last sample accepted at edge t: COMPUTE occupies edges t+1..t+2^LEVELS-1. m_valid is first high in the cycle after edge t+2^LEVELS-1, carrying A_L.
- Full throughput with m_ready=1: FRAME input cycles, then FRAME-1 compute cycles, then FRAME drain cycles per frame. No overlap between frames.
- The output is registered; m_valid has no combinational path from m_ready. s_ready depends only on state.
- m_ready low in DRAIN stalls indefinitely with no loss. m_ready toggling every cycle still yields the exact coefficient order.

## Structure
- Package dwt_pkg:
  - state enum (FILL/COMPUTE/DRAIN)
  - function frame_len(levels)
  - coefficient width constant DATA_W+1 (existing 9-bit convention at DATA_W=8)
- Sub-module haar_butterfly #(W): combinational avg/diff with the >>>1 and width rules above. It is reused unchanged by later parallel variants.
- Top: coefficient buffer (register array, FRAME entries), level/pair counters, FSM, output register.

## Test plan
- LEVELS=1, DATA_W=8; inputs 10,4 -> (m_data,m_level) = (7,0), (3,1); m_last on second; m_valid first in 2nd cycle after last accept.
- LEVELS=1; inputs -3,4 -> (0,0), (-4,1). Inputs 127,-128 -> (-1,0), (127,1). Inputs -128,127 -> (-1,0), (-128,1).
- LEVELS=2; inputs 8,4,2,6 -> (5,0), (1,2), (2,1), (-2,1); COMPUTE lasts exactly 3 cycles.
- LEVELS=3; random m_ready (about 50%) over 100 frames -> output matches reference model bit-exactly. No s_ready during COMPUTE/DRAIN. Outputs are held stable under stall.
- rst_n pulsed low mid-DRAIN after 2 of 8 coefficients -> next edge m_valid=0, busy=0. The next frame of 1..8 yields A_3=4 (floor cascade), with no stale coefficients.
- s_valid gapped (every third cycle) during FILL -> the frame is assembled correctly. The result is identical to a gap-free run.

Source files
------------

// File: rtl/dwt_pkg.sv
// Shared definitions for the frame-based Haar DWT engine: FSM encoding,
// frame sizing and coefficient width helpers.
package dwt_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_FILL    = 2'd0;
    localparam state_t ST_COMPUTE = 2'd1;
    localparam state_t ST_DRAIN   = 2'd2;

    // Coefficients carry one guard bit over the sample width.
    localparam int COEF_GUARD = 1;

    function automatic int frame_len(input int levels);
        return 32'sd1 << levels;
    endfunction

    function automatic int coef_width(input int data_w);
        return data_w + COEF_GUARD;
    endfunction

    localparam int DEFAULT_COEF_W = coef_width(8);

endpackage

// File: rtl/haar_butterfly.sv
// Combinational Haar butterfly: floor-rounded average and half-difference,
// computed one bit wider than the operands and truncated back to W bits.
module haar_butterfly #(
    parameter int W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] avg,
    output logic [W-1:0] diff
);

    logic signed [W:0] sum_s;
    logic signed [W:0] dif_s;

    assign sum_s = $signed(a) + $signed(b);
    assign dif_s = $signed(a) - $signed(b);

    // Dropping the LSB of the widened result is an arithmetic shift right by one.
    assign avg  = sum_s[W:1];
    assign diff = dif_s[W:1];

endmodule

// File: rtl/haar_dwt_frame.sv
// Multi-level Haar DWT over frames of 2^LEVELS samples: fill, one butterfly per
// cycle through all levels, then drain the coefficients in Mallat order.
module haar_dwt_frame
    import dwt_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LEVELS = 3,
    parameter int LVL_W  = $clog2(LEVELS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W:0]   m_data,
    output logic [LVL_W-1:0]  m_level,
    output logic              m_last,
    output logic              busy
);

    localparam int FRAME = frame_len(LEVELS);
    localparam int CW    = coef_width(DATA_W);
    localparam int IW    = LEVELS;
    localparam int CNT_W = LEVELS + 1;

    state_t           state_q,   state_d;
    logic [IW-1:0]    wr_cnt_q,  wr_cnt_d;
    logic [LVL_W-1:0] lvl_q,     lvl_d;
    logic [IW-1:0]    pair_q,    pair_d;
    logic [CNT_W-1:0] rd_cnt_q,  rd_cnt_d;
    logic             s_ready_q, s_ready_d;
    logic             busy_q,    busy_d;
    logic             m_valid_q, m_valid_d;
    logic [CW-1:0]    m_data_q,  m_data_d;
    logic [LVL_W-1:0] m_level_q, m_level_d;
    logic             m_last_q,  m_last_d;

    // buf holds the running averages in place; coef holds the Mallat-ordered output.
    logic [CW-1:0]    buf_q [FRAME];
    logic [CW-1:0]    buf_d [FRAME];
    logic [CW-1:0]    coef_q[FRAME];
    logic [CW-1:0]    coef_d[FRAME];

    logic [IW-1:0]    half_s;
    logic [IW-1:0]    idx_a_s;
    logic [IW-1:0]    idx_b_s;
    logic [CW-1:0]    bf_avg_s;
    logic [CW-1:0]    bf_diff_s;

    function automatic logic [LVL_W-1:0] level_of(input logic [CNT_W-1:0] idx);
        level_of = '0;
        for (int k = 1; k <= LEVELS; k++) begin
            if (int'(idx) >= (FRAME >> k) && int'(idx) < (FRAME >> (k - 1))) begin
                level_of = LVL_W'(k);
            end else begin
                level_of = level_of;
            end
        end
    endfunction

    assign half_s  = IW'(FRAME >> lvl_q);
    assign idx_a_s = IW'({pair_q, 1'b0});
    assign idx_b_s = IW'({pair_q, 1'b1});

    haar_butterfly #(.W(CW)) u_bf (
        .a    (buf_q[idx_a_s]),
        .b    (buf_q[idx_b_s]),
        .avg  (bf_avg_s),
        .diff (bf_diff_s)
    );

    // Next-state logic for the FSM, counters, buffers and output register.
    always_comb begin
        state_d   = state_q;
        wr_cnt_d  = wr_cnt_q;
        lvl_d     = lvl_q;
        pair_d    = pair_q;
        rd_cnt_d  = rd_cnt_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_level_d = m_level_q;
        m_last_d  = m_last_q;
        buf_d     = buf_q;
        coef_d    = coef_q;

        case (state_q)
            ST_FILL: begin
                if (s_valid && s_ready_q) begin
                    buf_d[wr_cnt_q] = {s_data[DATA_W-1], s_data};
                    if (wr_cnt_q == IW'(FRAME - 1)) begin
                        wr_cnt_d = '0;
                        lvl_d    = LVL_W'(1);
                        pair_d   = '0;
                        state_d  = ST_COMPUTE;
                    end else begin
                        wr_cnt_d = wr_cnt_q + IW'(1);
                    end
                end else begin
                    wr_cnt_d = wr_cnt_q;
                end
            end
            ST_COMPUTE: begin
                buf_d[pair_q]           = bf_avg_s;
                coef_d[half_s + pair_q] = bf_diff_s;
                if (pair_q == half_s - IW'(1)) begin
                    if (lvl_q == LVL_W'(LEVELS)) begin
                        // A_L goes straight to the output register on the final butterfly.
                        coef_d[0] = bf_avg_s;
                        m_valid_d = 1'b1;
                        m_data_d  = bf_avg_s;
                        m_level_d = '0;
                        m_last_d  = 1'b0;
                        rd_cnt_d  = CNT_W'(1);
                        lvl_d     = '0;
                        pair_d    = '0;
                        state_d   = ST_DRAIN;
                    end else begin
                        lvl_d  = lvl_q + LVL_W'(1);
                        pair_d = '0;
                    end
                end else begin
                    pair_d = pair_q + IW'(1);
                end
            end
            ST_DRAIN: begin
                if (m_valid_q && m_ready) begin
                    if (rd_cnt_q == CNT_W'(FRAME)) begin
                        m_valid_d = 1'b0;
                        m_last_d  = 1'b0;
                        rd_cnt_d  = '0;
                        state_d   = ST_FILL;
                    end else begin
                        m_data_d  = coef_q[rd_cnt_q[IW-1:0]];
                        m_level_d = level_of(rd_cnt_q);
                        m_last_d  = (rd_cnt_q == CNT_W'(FRAME - 1));
                        rd_cnt_d  = rd_cnt_q + CNT_W'(1);
                    end
                end else begin
                    rd_cnt_d = rd_cnt_q;
                end
            end
            default: begin
                state_d   = ST_FILL;
                m_valid_d = 1'b0;
            end
        endcase

        s_ready_d = (state_d == ST_FILL);
        busy_d    = (state_d != ST_FILL);
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_FILL;
            wr_cnt_q  <= '0;
            lvl_q     <= '0;
            pair_q    <= '0;
            rd_cnt_q  <= '0;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_level_q <= '0;
            m_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_cnt_q  <= wr_cnt_d;
            lvl_q     <= lvl_d;
            pair_q    <= pair_d;
            rd_cnt_q  <= rd_cnt_d;
            s_ready_q <= s_ready_d;
            busy_q    <= busy_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_level_q <= m_level_d;
            m_last_q  <= m_last_d;
        end
    end

    // Sample and coefficient storage; always rewritten before being read.
    always_ff @(posedge clk) begin
        buf_q  <= buf_d;
        coef_q <= coef_d;
    end

    assign s_ready = s_ready_q;
    assign busy    = busy_q;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_level = m_level_q;
    assign m_last  = m_last_q;

endmodule

// File: tb/tb_haar_dwt_frame.sv
// Bench for haar_dwt_frame: directed LEVELS=1/2 vectors, LEVELS=3 random
// frames with stalls, mid-drain reset and gapped input, against a scoreboard.
module tb_haar_dwt_frame;

    logic clk = 1'b0;
    logic rst_n;
    logic s_valid;
    logic [7:0] s_data;
    logic m_ready;
    int   sel;

    logic s_ready1, s_ready2, s_ready3;
    logic m_valid1, m_valid2, m_valid3;
    logic [8:0] m_data1, m_data2, m_data3;
    logic [0:0] m_level1;
    logic [1:0] m_level2, m_level3;
    logic m_last1, m_last2, m_last3;
    logic busy1, busy2, busy3;
    logic sv1, sv2, sv3;

    logic              obs_valid, obs_sready, obs_last, obs_busy;
    logic signed [8:0] obs_data;
    logic [2:0]        obs_level;

    typedef struct { int data; int level; int last; } exp_t;
    exp_t q[$];
    int   smp[32];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    assign sv1 = s_valid && (sel == 1);
    assign sv2 = s_valid && (sel == 2);
    assign sv3 = s_valid && (sel == 3);

    haar_dwt_frame #(.DATA_W(8), .LEVELS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .s_valid(sv1), .s_ready(s_ready1), .s_data(s_data),
        .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1), .m_level(m_level1),
        .m_last(m_last1), .busy(busy1));
    haar_dwt_frame #(.DATA_W(8), .LEVELS(2)) u2 (
        .clk(clk), .rst_n(rst_n), .s_valid(sv2), .s_ready(s_ready2), .s_data(s_data),
        .m_valid(m_valid2), .m_ready(m_ready), .m_data(m_data2), .m_level(m_level2),
        .m_last(m_last2), .busy(busy2));
    haar_dwt_frame #(.DATA_W(8), .LEVELS(3)) u3 (
        .clk(clk), .rst_n(rst_n), .s_valid(sv3), .s_ready(s_ready3), .s_data(s_data),
        .m_valid(m_valid3), .m_ready(m_ready), .m_data(m_data3), .m_level(m_level3),
        .m_last(m_last3), .busy(busy3));

    // Route the selected instance onto the observation signals.
    always_comb begin
        case (sel)
            1: begin
                obs_valid = m_valid1; obs_sready = s_ready1; obs_data = m_data1;
                obs_level = 3'(m_level1); obs_last = m_last1; obs_busy = busy1;
            end
            2: begin
                obs_valid = m_valid2; obs_sready = s_ready2; obs_data = m_data2;
                obs_level = 3'(m_level2); obs_last = m_last2; obs_busy = busy2;
            end
            default: begin
                obs_valid = m_valid3; obs_sready = s_ready3; obs_data = m_data3;
                obs_level = 3'(m_level3); obs_last = m_last3; obs_busy = busy3;
            end
        endcase
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int d, input int l, input int last);
        exp_t e;
        e.data = d; e.level = l; e.last = last;
        q.push_back(e);
    endtask

    // Reference Haar cascade in Mallat order, built from smp[0..2^L-1].
    task automatic expect_frame(input int L);
        int n, a[32], t[32], det[32], dlv[32], half;
        n = 1 << L;
        for (int i = 0; i < n; i++) a[i] = smp[i];
        for (int k = 1; k <= L; k++) begin
            half = n >> k;
            for (int p = 0; p < half; p++) begin
                t[p] = (a[2*p] + a[2*p+1]) >>> 1;
                det[half+p] = (a[2*p] - a[2*p+1]) >>> 1;
                dlv[half+p] = k;
            end
            for (int p = 0; p < half; p++) a[p] = t[p];
        end
        push_exp(a[0], 0, 0);
        for (int i = 1; i < n; i++) push_exp(det[i], dlv[i], (i == n - 1) ? 1 : 0);
    endtask

    task automatic send(input int x);
        int n = 0;
        @(negedge clk);
        while (!obs_sready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("send_timeout", n, 0);
        s_valid = 1'b1;
        s_data  = 8'(x);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic send_frame(input int L, input int gap);
        for (int i = 0; i < (1 << L); i++) begin
            repeat (gap) @(negedge clk);
            send(smp[i]);
        end
    endtask

    task automatic wait_latency(input string tag, input int exp_cycles);
        int n = 0;
        chk({tag, "_busy"}, obs_busy, 1);
        while (!obs_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
            if (!obs_valid) chk({tag, "_sready_compute"}, obs_sready, 0);
        end
        chk({tag, "_latency"}, n, exp_cycles);
    endtask

    task automatic recv(input int n, input bit rnd, input bit fin);
        int got = 0, cyc = 0;
        bit prev_stall = 1'b0;
        int pd = 0, pl = 0, plast = 0;
        exp_t e;
        while (got < n && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (prev_stall) begin
                chk("hold_data", obs_data, pd);
                chk("hold_level", obs_level, pl);
                chk("hold_last", obs_last, plast);
            end
            if (obs_valid) chk("sready_drain", obs_sready, 0);
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (obs_valid && m_ready) begin
                if (q.size() == 0) begin
                    chk("scoreboard_empty", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("coef_data", obs_data, e.data);
                    chk("coef_level", obs_level, e.level);
                    chk("coef_last", obs_last, e.last);
                end
                got++;
            end
            prev_stall = obs_valid && !m_ready;
            pd = obs_data; pl = obs_level; plast = obs_last;
        end
        if (got < n) chk("recv_timeout", got, n);
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        if (fin) begin
            chk("end_valid", obs_valid, 0);
            chk("end_busy", obs_busy, 0);
            chk("end_sready", obs_sready, 1);
        end
    endtask

    task automatic rand_frame();
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r = 8'($urandom);
            smp[i] = int'($signed(r));
        end
    endtask

    initial begin
        rst_n = 1'b0; s_valid = 1'b0; s_data = 8'd0; m_ready = 1'b0; sel = 3;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", obs_valid, 0);
        chk("rst_data", obs_data, 0);
        chk("rst_level", obs_level, 0);
        chk("rst_last", obs_last, 0);
        chk("rst_busy", obs_busy, 0);
        chk("rst_sready", obs_sready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_sready", obs_sready, 1);

        // LEVELS=1 directed pairs.
        sel = 1;
        push_exp(7, 0, 0); push_exp(3, 1, 1);
        send(10); send(4);
        wait_latency("l1", 1);
        recv(2, 1'b0, 1'b1);
        push_exp(0, 0, 0); push_exp(-4, 1, 1);
        send(-3); send(4);
        recv(2, 1'b0, 1'b1);
        push_exp(-1, 0, 0); push_exp(127, 1, 1);
        send(127); send(-128);
        recv(2, 1'b0, 1'b1);
        push_exp(-1, 0, 0); push_exp(-128, 1, 1);
        send(-128); send(127);
        recv(2, 1'b0, 1'b1);

        // LEVELS=2 directed frame.
        sel = 2;
        push_exp(5, 0, 0); push_exp(1, 2, 0); push_exp(2, 1, 0); push_exp(-2, 1, 1);
        send(8); send(4); send(2); send(6);
        wait_latency("l2", 3);
        recv(4, 1'b0, 1'b1);

        // LEVELS=3 random frames with random backpressure.
        sel = 3;
        for (int f = 0; f < 100; f++) begin
            rand_frame();
            if (f == 0) begin
                smp[0] = 127; smp[1] = -128; smp[2] = -128; smp[3] = 127;
            end
            expect_frame(3);
            send_frame(3, 0);
            if (f == 0) wait_latency("l3", 7);
            recv(8, 1'b1, 1'b1);
        end

        // Reset in the middle of DRAIN discards the frame.
        rand_frame();
        expect_frame(3);
        send_frame(3, 0);
        recv(2, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_valid", obs_valid, 0);
        chk("mid_rst_busy", obs_busy, 0);
        chk("mid_rst_sready", obs_sready, 0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_release_sready", obs_sready, 1);
        for (int i = 0; i < 8; i++) smp[i] = i + 1;
        expect_frame(3);
        send_frame(3, 0);
        wait_latency("after_rst", 7);
        chk("a3_floor", obs_data, 4);
        recv(8, 1'b0, 1'b1);

        // Gapped input (every third cycle) versus the same frame gap-free.
        rand_frame();
        expect_frame(3);
        send_frame(3, 2);
        recv(8, 1'b1, 1'b1);
        expect_frame(3);
        send_frame(3, 0);
        recv(8, 1'b0, 1'b1);
        chk("scoreboard_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
